// File: rtl/md_unit.sv
// HI/LO multiply-divide unit for the EX stage.
// Results are computed at accept and committed after a fixed busy countdown.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        rd_sel,
  output logic [7:0]  busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [7:0] MULT_L = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_L  = 8'(DIV_CYCLES);

  logic [7:0]  busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] res_hi, res_lo;
  logic        res_ok;

  logic [63:0] prod_s, prod_u;
  logic [31:0] b_nz;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic        div_ovf;
  logic        b_zero;

  always_comb begin
    prod_s  = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u  = {32'd0, src_a} * {32'd0, src_b};
    b_zero  = (src_b == 32'd0);
    // Keep the dividers away from zero; the result is discarded then.
    b_nz    = b_zero ? 32'd1 : src_b;
    div_ovf = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    q_u     = src_a / b_nz;
    r_u     = src_a % b_nz;
    q_s     = 32'($signed(src_a) / $signed(b_nz));
    r_s     = 32'($signed(src_a) % $signed(b_nz));
    if (div_ovf) begin
      q_s = 32'h8000_0000;
      r_s = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 8'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_ok <= 1'b0;
    end else if (busy_q != 8'd0) begin
      if (busy_q == 8'd1) begin
        busy_q <= 8'd0;
        if (res_ok) begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      end else begin
        busy_q <= busy_q - 8'd1;
      end
    end else if (md_start) begin
      case (md_op)
        OP_MULT: begin
          {res_hi, res_lo} <= prod_s;
          res_ok <= 1'b1;
          busy_q <= MULT_L;
        end
        OP_MULTU: begin
          {res_hi, res_lo} <= prod_u;
          res_ok <= 1'b1;
          busy_q <= MULT_L;
        end
        OP_DIV: begin
          res_hi <= r_s;
          res_lo <= q_s;
          res_ok <= !b_zero;
          busy_q <= DIV_L;
        end
        OP_DIVU: begin
          res_hi <= r_u;
          res_lo <= q_u;
          res_ok <= !b_zero;
          busy_q <= DIV_L;
        end
        OP_MTHI: hi_q <= src_a;
        OP_MTLO: lo_q <= src_a;
        default: ;
      endcase
    end
  end

  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_rdata = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: arithmetic vector table plus
// hand sequences for MTHI/MTLO, divide by zero, busy guard and reset abort.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        rd_sel;
  logic [7:0]  busy;
  logic [31:0] hi, lo, md_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .rd_sel(rd_sel),
    .busy(busy), .hi(hi), .lo(lo), .md_rdata(md_rdata)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    md_start = 1'b1;
    md_op    = op;
    src_a    = a;
    src_b    = b;
    tick();
    md_start = 1'b0;
    md_op    = 3'd0;
    src_a    = $urandom;
    src_b    = $urandom;
  endtask

  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat);
    issue(op, a, b);
    for (int k = lat; k >= 1; k--) begin
      check({name, " busy"}, {24'd0, busy}, 32'(k));
      tick();
    end
    check({name, " busy0"}, {24'd0, busy}, 32'd0);
    check({name, " hi"}, hi, ehi);
    check({name, " lo"}, lo, elo);
    rd_sel = 1'b1;
    #1;
    check({name, " rdata_hi"}, md_rdata, ehi);
    rd_sel = 1'b0;
    #1;
    check({name, " rdata_lo"}, md_rdata, elo);
  endtask

  initial begin
    vecs[0]  = '{"mult_neg2x3", 3'd1, 32'hFFFFFFFE, 32'd3,
                 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{"multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2]  = '{"div_m7_2", 3'd3, 32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{"divu_7_2", 3'd4, 32'd7, 32'd2,
                 32'd1, 32'd3, 10};
    vecs[4]  = '{"div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF,
                 32'd0, 32'h80000000, 10};
    vecs[5]  = '{"div_100_m7", 3'd3, 32'd100, 32'hFFFFFFF9,
                 32'd2, 32'hFFFFFFF2, 10};
    vecs[6]  = '{"div_m100_7", 3'd3, 32'hFFFFFF9C, 32'd7,
                 32'hFFFFFFFE, 32'hFFFFFFF2, 10};
    vecs[7]  = '{"mult_min_sq", 3'd1, 32'h80000000, 32'h80000000,
                 32'h40000000, 32'd0, 5};
    vecs[8]  = '{"multu_2p31x2", 3'd2, 32'h80000000, 32'd2,
                 32'd1, 32'd0, 5};
    vecs[9]  = '{"mult_max_m1", 3'd1, 32'h7FFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFF, 32'h80000001, 5};
    vecs[10] = '{"divu_big", 3'd4, 32'hFFFFFFFF, 32'h00010000,
                 32'h0000FFFF, 32'h0000FFFF, 10};

    reset    = 1'b1;
    md_start = 1'b0;
    md_op    = 3'd0;
    src_a    = 32'd0;
    src_b    = 32'd0;
    rd_sel   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset busy", {24'd0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset rdata", md_rdata, 32'd0);

    // NONE and reserved must not start anything
    issue(3'd0, 32'd9, 32'd9);
    check("none busy", {24'd0, busy}, 32'd0);
    issue(3'd7, 32'd9, 32'd9);
    check("rsvd busy", {24'd0, busy}, 32'd0);
    check("rsvd lo", lo, 32'd0);

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].ehi, vecs[i].elo, vecs[i].lat);

    // MTHI then MTLO back to back
    rd_sel = 1'b1;
    issue(3'd5, 32'h12345678, 32'd0);
    check("mthi busy", {24'd0, busy}, 32'd0);
    check("mthi hi", hi, 32'h12345678);
    check("mthi rdata", md_rdata, 32'h12345678);
    issue(3'd6, 32'h9ABCDEF0, 32'd0);
    check("mtlo busy", {24'd0, busy}, 32'd0);
    check("mtlo lo", lo, 32'h9ABCDEF0);
    check("mtlo hi kept", hi, 32'h12345678);
    rd_sel = 1'b0;
    #1;
    check("mtlo rdata", md_rdata, 32'h9ABCDEF0);

    // divide by zero leaves HI/LO alone
    issue(3'd5, 32'hAAAA0000, 32'd0);
    issue(3'd6, 32'h0000BBBB, 32'd0);
    run_op("div_by0", 3'd3, 32'd77, 32'd0,
           32'hAAAA0000, 32'h0000BBBB, 10);
    run_op("divu_by0", 3'd4, 32'd77, 32'd0,
           32'hAAAA0000, 32'h0000BBBB, 10);

    // start requests while busy are ignored
    issue(3'd1, 32'd2, 32'd3);
    check("guard busy5", {24'd0, busy}, 32'd5);
    tick();
    tick();
    check("guard busy3", {24'd0, busy}, 32'd3);
    issue(3'd6, 32'd5, 32'd0);
    check("guard busy2", {24'd0, busy}, 32'd2);
    check("guard lo held", lo, 32'h0000BBBB);
    issue(3'd1, 32'd100, 32'd100);
    check("guard busy1", {24'd0, busy}, 32'd1);
    tick();
    check("guard commit busy", {24'd0, busy}, 32'd0);
    check("guard commit hi", hi, 32'd0);
    check("guard commit lo", lo, 32'd6);

    // reset mid-divide aborts and discards the result
    issue(3'd4, 32'd7, 32'd2);
    for (int k = 0; k < 6; k++) tick();
    check("abort busy4", {24'd0, busy}, 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", {24'd0, busy}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    for (int k = 0; k < 12; k++) tick();
    check("abort late busy", {24'd0, busy}, 32'd0);
    check("abort late hi", hi, 32'd0);
    check("abort late lo", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
